inst_loader_ctrl: RTL

INST_LOADER_CTRL -- requirements
Module: inst_loader_ctrl

---
 rtl/inst_loader_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_loader_ctrl.sv
// inst_loader_ctrl
// Receives a boot image as a byte stream and writes it into instruction RAM.
// The core is held in reset until the image has been loaded.
//
// Stream format, every 32-bit word least-significant byte first:
//   word count N, then N instruction words, then (checksum build only) one
//   trailer word equal to the modulo-2^32 sum of the N data words.
//
// Optional feature macro: INST_LOADER_CHECKSUM_EN
//   When defined, the CSUM state and the running-sum logic are built in.
//   When undefined, neither exists, and a load that would have gone to CSUM
//   goes straight to DONE.
//
// Parameters:
//   w      instruction word / address width
//   DEPTH  maximum loadable word count
//   BASE   byte address of the first loaded word
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   load_req   pulse: start a load (honoured in IDLE, DONE, ERR)
//   run_req    pulse: release the core without loading (honoured in IDLE)
//   rx_valid   a byte is present on rx_data this cycle
//   rx_data    stream byte
//   is_write   instruction RAM write strobe, one cycle per word
//   im_addr    instruction RAM byte address (held between writes)
//   im_inst    instruction RAM write data (held between writes)
//   core_rst   holds the core in reset while high
//   busy       high in HDR, DATA and CSUM
//   load_done  sticky success flag
//   load_err   sticky failure flag
//   state_dbg  current FSM state, for observation only
//
// Handshake: rx_valid has no back-pressure. Every cycle with rx_valid high in
// HDR, DATA or CSUM consumes exactly one byte; bytes in any other state are
// dropped.
module inst_loader_ctrl #(
  parameter int          w     = 32,
  parameter int          DEPTH = 2048,
  parameter int unsigned BASE  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_req,
  input  logic         run_req,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         is_write,
  output logic [w-1:0] im_addr,
  output logic [w-1:0] im_inst,
  output logic         core_rst,
  output logic         busy,
  output logic         load_done,
  output logic         load_err,
  output logic [2:0]   state_dbg
);

  // Wide enough to hold DEPTH itself.
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
`ifdef INST_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  state_t         state;
  logic [1:0]     byte_cnt;
  logic [7:0]     byte0, byte1, byte2;
  logic [CW-1:0]  n_words;
  logic [CW-1:0]  word_idx;
  logic [31:0]    rx_word;
  logic           byte_last;
  logic           start;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0]    csum;
`endif

  // The word completed by the byte arriving this cycle.
  assign rx_word   = {rx_data, byte2, byte1, byte0};
  assign byte_last = rx_valid && (byte_cnt == 2'd3);
  assign start     = load_req && (state == IDLE || state == DONE || state == ERR);

`ifdef INST_LOADER_CHECKSUM_EN
  assign busy = (state == HDR) || (state == DATA) || (state == CSUM);
`else
  assign busy = (state == HDR) || (state == DATA);
`endif

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      im_addr   <= '0;
      im_inst   <= '0;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      byte_cnt  <= 2'd0;
      byte0     <= 8'd0;
      byte1     <= 8'd0;
      byte2     <= 8'd0;
      n_words   <= '0;
      word_idx  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum      <= 32'd0;
`endif
    end else begin
      is_write <= 1'b0;

      if (start) begin
        state     <= HDR;
        core_rst  <= 1'b1;
        load_done <= 1'b0;
        load_err  <= 1'b0;
        byte_cnt  <= 2'd0;
        word_idx  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
        csum      <= 32'd0;
`endif
      end else begin
        if (state == IDLE && run_req)
          core_rst <= 1'b0;

        // Byte assembly is shared by every stream-consuming state.
        if (busy && rx_valid) begin
          byte_cnt <= byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0:    byte0 <= rx_data;
            2'd1:    byte1 <= rx_data;
            2'd2:    byte2 <= rx_data;
            default: ;
          endcase
        end

        case (state)
          HDR: begin
            if (byte_last) begin
              if (rx_word == 32'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                state <= CSUM;
`else
                state     <= DONE;
                load_done <= 1'b1;
                core_rst  <= 1'b0;
`endif
              end else if (rx_word > 32'(DEPTH)) begin
                state    <= ERR;
                load_err <= 1'b1;
              end else begin
                n_words <= CW'(rx_word);
                state   <= DATA;
              end
            end
          end

          DATA: begin
            if (byte_last) begin
              im_inst  <= w'(rx_word);
              im_addr  <= w'(BASE) + (w'(word_idx) << 2);
              is_write <= 1'b1;
              word_idx <= word_idx + CW'(1);
`ifdef INST_LOADER_CHECKSUM_EN
              csum     <= csum + rx_word;
`endif
              if (word_idx == n_words - CW'(1)) begin
`ifdef INST_LOADER_CHECKSUM_EN
                state <= CSUM;
`else
                state     <= DONE;
                load_done <= 1'b1;
                core_rst  <= 1'b0;
`endif
              end
            end
          end

`ifdef INST_LOADER_CHECKSUM_EN
          CSUM: begin
            if (byte_last) begin
              if (rx_word == csum) begin
                state     <= DONE;
                load_done <= 1'b1;
                core_rst  <= 1'b0;
              end else begin
                state    <= ERR;
                load_err <= 1'b1;
              end
            end
          end
`endif

          default: ;
        endcase
      end
    end
  end

endmodule
